sdram_write: RTL and testbench

SDRAM_WRITE -- requirements
Module: sdram_write

---
 rtl/sdram_write_if.sv | 41 ++++
 rtl/sdram_write.sv | 152 +++++++++++++++
 tb/tb_sdram_write.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_write_if.sv
// sdram_write_if -- bundle of the user-side handshake and SDRAM command bus
// used by the sdram_write block.
//
// Valid/ready semantics: the user presents wr_en with a stable wr_addr and
// wr_bst_len; the write engine consumes wr_data on every cycle in which
// wr_ack is high (one word per acked cycle), and the user must present the
// next word before the following cycle. wr_end pulses once per transaction.
//
// Signals:
//   wr_en, wr_addr[23:0], wr_data[15:0], wr_bst_len[9:0], init_end  (user -> engine)
//   wr_ack, wr_end                                                    (engine -> user)
//   wr_sdram_cmd[3:0], wr_sdram_bank[1:0], wr_sdram_addr[12:0],
//   wr_sdram_en, wr_sdram_data[15:0]                                  (engine -> SDRAM)
//
// Modports: slave = write engine, master = user / stimulus side.
interface sdram_write_if;
    logic        wr_en;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic [9:0]  wr_bst_len;
    logic        init_end;
    logic        wr_ack;
    logic        wr_end;
    logic [3:0]  wr_sdram_cmd;
    logic [1:0]  wr_sdram_bank;
    logic [12:0] wr_sdram_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_bst_len, init_end,
        output wr_ack, wr_end, wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr,
               wr_sdram_en, wr_sdram_data
    );

    modport master (
        output wr_en, wr_addr, wr_data, wr_bst_len, init_end,
        input  wr_ack, wr_end, wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr,
               wr_sdram_en, wr_sdram_data
    );
endinterface

// File: rtl/sdram_write.sv
// sdram_write -- SDRAM burst write sequencer.
// Issues ACTIVE, waits TRCD_CLK, issues WRITE and streams wr_bst_len words
// (0 treated as 1), then PRECHARGE all banks, waits TRP_CLK and pulses wr_end.
//
// Ports:
//   wr_clk       rising-edge clock
//   wr_rst_n     asynchronous active-low reset
//   bus          sdram_write_if.slave (user handshake + SDRAM command bus)
//   dbg_state_o  current FSM state encoding, for observation
//
// Optional feature macro: SDRAM_WR_BURST_STOP_EN
//   defined   -> one BURST_STOP tail cycle after the last word, before PRE
//   undefined -> DATA goes straight to PRE; PRECHARGE ends the burst
//
// All outputs are decoded from the registered state and cycle counter, so an
// asserted reset drives them to their idle values without waiting for a clock.
module sdram_write #(
    parameter int TRCD_CLK = 2,
    parameter int TRP_CLK  = 2
) (
    input  logic              wr_clk,
    input  logic              wr_rst_n,
    sdram_write_if.slave      bus,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_ACT  = 3'b001,
        S_TRCD = 3'b011,
        S_WR   = 3'b010,
        S_DATA = 3'b100,
        S_PRE  = 3'b101,
        S_TRP  = 3'b111,
        S_END  = 3'b110
    } state_t;

    localparam logic [3:0] CMD_NOP        = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [3:0] CMD_WRITE      = 4'b0100;
    localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;

    localparam logic [9:0] TRCD_LAST = 10'(TRCD_CLK - 1);
    localparam logic [9:0] TRP_LAST  = 10'(TRP_CLK - 1);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [9:0] bst_len;
    logic [9:0] data_last;

    logic [3:0]  cmd_s;
    logic [1:0]  bank_s;
    logic [12:0] addr_s;
    logic        ack_s;
    logic        en_s;
    logic        end_s;

    // A zero-length request still writes one word.
    assign bst_len = (bus.wr_bst_len == 10'd0) ? 10'd1 : bus.wr_bst_len;

    // Counter value of the final DATA cycle. The WR cycle carries word 1, so
    // DATA carries words 2..N (N-1 cycles), plus the stop tail when enabled.
`ifdef SDRAM_WR_BURST_STOP_EN
    assign data_last = bst_len - 10'd1;
`else
    assign data_last = bst_len - 10'd2;
`endif

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.wr_en && bus.init_end) state_d = S_ACT;
            S_ACT:  state_d = S_TRCD;
            S_TRCD: if (cnt_q == TRCD_LAST) state_d = S_WR;
`ifdef SDRAM_WR_BURST_STOP_EN
            S_WR:   state_d = S_DATA;
`else
            S_WR:   state_d = (bst_len == 10'd1) ? S_PRE : S_DATA;
`endif
            S_DATA: if (cnt_q == data_last) state_d = S_PRE;
            S_PRE:  state_d = S_TRP;
            S_TRP:  if (cnt_q == TRP_LAST) state_d = S_END;
            S_END:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Counter restarts on every state change; held at 0 while idle.
        cnt_d = (state_d != state_q || state_q == S_IDLE) ? 10'd0 : cnt_q + 10'd1;
    end

    always_comb begin
        cmd_s  = CMD_NOP;
        bank_s = 2'b11;
        addr_s = 13'h1FFF;
        ack_s  = 1'b0;
        en_s   = 1'b0;
        end_s  = 1'b0;
        case (state_q)
            S_ACT: begin
                cmd_s  = CMD_ACTIVE;
                bank_s = bus.wr_addr[23:22];
                addr_s = bus.wr_addr[21:9];
            end
            S_WR: begin
                cmd_s  = CMD_WRITE;
                bank_s = bus.wr_addr[23:22];
                addr_s = {4'b0000, bus.wr_addr[8:0]};
                ack_s  = 1'b1;
                en_s   = 1'b1;
            end
            S_DATA: begin
`ifdef SDRAM_WR_BURST_STOP_EN
                if (cnt_q == data_last) begin
                    cmd_s = CMD_BURST_STOP;
                end else begin
                    ack_s = 1'b1;
                    en_s  = 1'b1;
                end
`else
                ack_s = 1'b1;
                en_s  = 1'b1;
`endif
            end
            S_PRE: begin
                cmd_s  = CMD_PRECHARGE;
                addr_s = 13'h0400;
            end
            S_END: end_s = 1'b1;
            default: ;
        endcase
    end

    assign bus.wr_sdram_cmd  = cmd_s;
    assign bus.wr_sdram_bank = bank_s;
    assign bus.wr_sdram_addr = addr_s;
    assign bus.wr_ack        = ack_s;
    assign bus.wr_sdram_en   = en_s;
    assign bus.wr_end        = end_s;
    assign bus.wr_sdram_data = en_s ? bus.wr_data : 16'h0000;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_sdram_write.sv
// tb_sdram_write -- directed + randomized bench for sdram_write.
// The reference model expands each request into its expected per-cycle
// command trace (state, cmd, bank, addr, ack, en, end) from the protocol
// rules, queues it, and the bench compares every cycle on the falling edge.
module tb_sdram_write;
  localparam int TRCD = 2;
  localparam int TRP  = 2;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_BS  = 4'b0110;
  localparam logic [3:0] C_PRE = 4'b0010;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_ACT  = 3'b001;
  localparam logic [2:0] S_TRCD = 3'b011;
  localparam logic [2:0] S_WR   = 3'b010;
  localparam logic [2:0] S_DATA = 3'b100;
  localparam logic [2:0] S_PRE  = 3'b101;
  localparam logic [2:0] S_TRP  = 3'b111;
  localparam logic [2:0] S_END  = 3'b110;

  // clock / reset
  logic       wr_clk = 1'b0;
  logic       wr_rst_n = 1'b0;
  logic [2:0] dbg_state;
  always #5 wr_clk = ~wr_clk;

  sdram_write_if bus();

  sdram_write #(.TRCD_CLK(TRCD), .TRP_CLK(TRP)) dut (
    .wr_clk      (wr_clk),
    .wr_rst_n    (wr_rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // scoreboard
  logic [24:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [24:0] pk(input logic [2:0] st, input logic [3:0] cmd,
                                     input logic [1:0] bank, input logic [12:0] addr,
                                     input logic ack, input logic en, input logic endp);
    return {st, cmd, bank, addr, ack, en, endp};
  endfunction

  function automatic logic [24:0] observed();
    return {dbg_state, bus.wr_sdram_cmd, bus.wr_sdram_bank, bus.wr_sdram_addr,
            bus.wr_ack, bus.wr_sdram_en, bus.wr_end};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: expected trace of one transaction
  task automatic build_exp(input logic [23:0] a, input logic [9:0] len);
    int n;
    n = (len == 0) ? 1 : int'(len);
    exp_q.delete();
    exp_q.push_back(pk(S_ACT, C_ACT, a[23:22], a[21:9], 0, 0, 0));
    for (int i = 0; i < TRCD; i++) exp_q.push_back(pk(S_TRCD, C_NOP, 2'b11, 13'h1FFF, 0, 0, 0));
    exp_q.push_back(pk(S_WR, C_WR, a[23:22], {4'b0000, a[8:0]}, 1, 1, 0));
    for (int i = 1; i < n; i++) exp_q.push_back(pk(S_DATA, C_NOP, 2'b11, 13'h1FFF, 1, 1, 0));
`ifdef SDRAM_WR_BURST_STOP_EN
    exp_q.push_back(pk(S_DATA, C_BS, 2'b11, 13'h1FFF, 0, 0, 0));
`endif
    exp_q.push_back(pk(S_PRE, C_PRE, 2'b11, 13'h0400, 0, 0, 0));
    for (int i = 0; i < TRP; i++) exp_q.push_back(pk(S_TRP, C_NOP, 2'b11, 13'h1FFF, 0, 0, 0));
    exp_q.push_back(pk(S_END, C_NOP, 2'b11, 13'h1FFF, 0, 0, 1));
  endtask

  // driver: issue a request at a falling edge, then check `limit` cycles
  // (limit < 0 -> whole transaction plus the return to IDLE).
  task automatic run_txn(input logic [23:0] a, input logic [9:0] len, input int limit);
    logic [15:0] base;
    logic [24:0] e;
    int k, cyc, n_bs;
    build_exp(a, len);
    bus.wr_addr = a;
    bus.wr_bst_len = len;
    bus.init_end = 1'b1;
    bus.wr_en = 1'b1;
    base = bus.wr_data;
    k = 0;
    cyc = 0;
    n_bs = 0;
    while (exp_q.size() > 0 && (limit < 0 || cyc < limit)) begin
      @(negedge wr_clk);
      e = exp_q.pop_front();
      check("trace", 32'(observed()), 32'(e));
      check("data", 32'(bus.wr_sdram_data), e[1] ? 32'(base + 16'(k)) : 32'd0);
      if (bus.wr_sdram_cmd == C_BS) n_bs++;
      if (e[2]) begin
        k++;
        bus.wr_data = bus.wr_data + 16'd1;
      end
      cyc++;
      // request lines must be ignored once the transaction has started
      if (e[0] || exp_q.size() == 0) begin
        bus.wr_en = 1'b0;
        bus.init_end = 1'b1;
      end else begin
        bus.wr_en = 1'($urandom_range(0, 1));
        bus.init_end = 1'($urandom_range(0, 1));
      end
    end
    if (limit < 0) begin
`ifdef SDRAM_WR_BURST_STOP_EN
      check("burst_stop_count", 32'(n_bs), 32'd1);
`else
      check("burst_stop_count", 32'(n_bs), 32'd0);
`endif
      @(negedge wr_clk);
      check("back_idle", 32'(observed()), 32'(pk(S_IDLE, C_NOP, 2'b11, 13'h1FFF, 0, 0, 0)));
    end
  endtask

  initial begin
    logic [24:0] idle_v;
    idle_v = pk(S_IDLE, C_NOP, 2'b11, 13'h1FFF, 0, 0, 0);
    bus.wr_en = 1'b0;
    bus.wr_addr = 24'h0;
    bus.wr_data = 16'h0;
    bus.wr_bst_len = 10'd0;
    bus.init_end = 1'b0;

    // reset state
    repeat (2) @(negedge wr_clk);
    check("reset_state", 32'(observed()), 32'(idle_v));
    check("reset_data", 32'(bus.wr_sdram_data), 32'd0);
    wr_rst_n = 1'b1;

    // init gating
    bus.wr_en = 1'b1;
    bus.init_end = 1'b0;
    repeat (100) begin
      @(negedge wr_clk);
      check("init_gate", 32'(observed()), 32'(idle_v));
    end
    bus.wr_en = 1'b0;
    @(negedge wr_clk);

    // basic burst, data incrementing from 0
    bus.wr_data = 16'h0000;
    run_txn(24'h000000, 10'd10, -1);

    // address split
    run_txn(24'hC03E05, 10'd3, -1);

    // length edges
    run_txn(24'h123456, 10'd1, -1);
    run_txn(24'h654321, 10'd0, -1);

    // randomized requests
    for (int t = 0; t < 10; t++) begin
      bus.wr_data = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge wr_clk);
      run_txn(24'($urandom), 10'($urandom_range(0, 20)), -1);
    end
    run_txn(24'($urandom), 10'd512, -1);

    // reset on the 4th DATA-state cycle
    run_txn(24'($urandom), 10'd10, 8);
    wr_rst_n = 1'b0;
    #1;
    check("mid_reset_state", 32'(observed()), 32'(idle_v));
    check("mid_reset_data", 32'(bus.wr_sdram_data), 32'd0);
    @(negedge wr_clk);
    check("held_reset", 32'(observed()), 32'(idle_v));
    wr_rst_n = 1'b1;
    bus.wr_data = 16'($urandom);
    run_txn(24'($urandom), 10'd6, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
